// File: rtl/cs_seq.sv
// cs_seq: frame sequencer for a sliding averaging datapath.
// Each frame clears the datapath, primes it with 8 samples, and then streams
// one result per further sample with a 2-cycle sample-to-result latency.
// Results are held under downstream backpressure. A start pulse aborts any
// frame in progress.
module cs_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] frame_len,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        dp_clr,
    output logic        dp_shift,
    output logic [7:0]  dp_x,
    input  logic [9:0]  dp_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [9:0]  out_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FILL  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [15:0] MIN_LEN   = 16'd9;
    localparam logic [15:0] FILL_LAST = 16'd7;

    // Frames shorter than the priming depth plus one result are stretched.
    function automatic logic [15:0] clamp_len(input logic [15:0] len);
        if (len < MIN_LEN) begin
            return MIN_LEN;
        end else begin
            return len;
        end
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic [15:0] count_r;
    logic [15:0] length_r;
    logic        pending_r;
    logic        out_valid_r;
    logic [9:0]  out_data_r;
    logic        in_ready_s;
    logic        accept_s;
    logic        restart_s;
    logic        handoff_ok_s;
    logic        dp_clr_s;
    logic        busy_s;
    logic        done_s;

    // A start in CLEAR is ignored: CLEAR lasts exactly one cycle.
    assign restart_s    = start & (state_r != ST_CLEAR);
    // The output slot is free now, or it is freed at this clock edge.
    assign handoff_ok_s = ~out_valid_r | out_ready;
    assign accept_s     = in_valid & in_ready_s;

    assign in_ready  = in_ready_s;
    assign dp_shift  = accept_s;
    assign dp_x      = in_data;
    assign dp_clr    = dp_clr_s;
    assign busy      = busy_s;
    assign done      = done_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

    // State register with asynchronous reset to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; start has priority over every other transition.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_CLEAR;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                next_state_s = ST_FILL;
            end
            ST_FILL: begin
                if (start) begin
                    next_state_s = ST_CLEAR;
                end else if (accept_s && (count_r == FILL_LAST)) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_FILL;
                end
            end
            ST_RUN: begin
                if (start) begin
                    next_state_s = ST_CLEAR;
                end else if ((count_r == length_r) && !pending_r && handoff_ok_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    next_state_s = ST_CLEAR;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: handshake readiness and datapath/status strobes.
    always_comb begin
        in_ready_s = 1'b0;
        dp_clr_s   = 1'b0;
        busy_s     = 1'b1;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_CLEAR: begin
                dp_clr_s = 1'b1;
            end
            ST_FILL: begin
                in_ready_s = ~start;
            end
            ST_RUN: begin
                in_ready_s = ~start & ~pending_r & handoff_ok_s & (count_r < length_r);
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Frame bookkeeping: length latch, sample count, result pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            length_r    <= MIN_LEN;
            count_r     <= 16'd0;
            pending_r   <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= 10'd0;
        end else begin
            if (restart_s) begin
                length_r <= clamp_len(frame_len);
            end else begin
                length_r <= length_r;
            end
            if (restart_s || (state_r == ST_CLEAR)) begin
                count_r     <= 16'd0;
                pending_r   <= 1'b0;
                out_valid_r <= 1'b0;
            end else begin
                if (accept_s) begin
                    count_r <= count_r + 16'd1;
                end
                // dp_y reflects a RUN sample one cycle after its acceptance.
                pending_r <= accept_s & (state_r == ST_RUN);
                if (pending_r) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= dp_y;
                end else if (out_valid_r && out_ready) begin
                    out_valid_r <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cs_seq.sv
// Testbench for cs_seq: randomized frames against a sample-list reference model.
module tb_cs_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] frame_len = 16'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        dp_clr;
    logic        dp_shift;
    logic [7:0]  dp_x;
    logic [9:0]  dp_y = 10'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [9:0]  out_data;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [15:0] dp_idx = 16'd0;

    cs_seq dut (
        .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dp_clr(dp_clr), .dp_shift(dp_shift), .dp_x(dp_x), .dp_y(dp_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: result = 1-based accept index + sample value.
    always @(posedge clk) begin
        if (dp_clr) begin
            dp_idx <= 16'd0;
            dp_y   <= 10'd0;
        end else if (dp_shift) begin
            dp_idx <= dp_idx + 16'd1;
            dp_y   <= 10'(dp_idx + 16'd1) + {2'b00, dp_x};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // One frame: start, CLEAR, then sample/result traffic until done or abort.
    task automatic run_frame(input int flen, input int pv, input int pr,
                             input bit zero_data, input bit bp, input int abort_at);
        int L;
        logic [7:0] data[];
        logic [9:0] want_q[$];
        int acc_cyc_q[$];
        int src = 0;
        int got = 0;
        int cyc = 0;
        int bp_left = 0;
        bit bp_started = 0;
        bit done_seen = 0;
        bit aborted = 0;
        logic ov_prev = 1'b0;
        logic or_prev = 1'b0;
        logic [9:0] od_prev = 10'd0;
        logic acc;
        L = (flen < 9) ? 9 : flen;
        data = new[L];
        for (int k = 0; k < L; k++) begin
            data[k] = zero_data ? 8'd0 : 8'($urandom);
            if (k >= 8) want_q.push_back(10'(k + 1) + {2'b00, data[k]});
        end
        frame_len = 16'(flen);
        start = 1'b1;
        in_valid = 1'b1;
        in_data = 8'($urandom);
        out_ready = 1'b1;
        @(negedge clk);
        chk("start_no_shift", dp_shift, 0);
        @(posedge clk); #1;
        start = 1'b0;
        frame_len = 16'($urandom_range(0, 8));
        @(negedge clk);
        chk("clear_dp_clr", dp_clr, 1);
        chk("clear_in_ready", in_ready, 0);
        chk("clear_out_valid", out_valid, 0);
        chk("clear_busy", busy, 1);
        @(posedge clk); #1;
        while (!done_seen && !aborted && cyc < 3000) begin
            start = 1'b0;
            if (src < L) begin
                in_valid = ($urandom_range(99) < pv);
                in_data = data[src];
            end else begin
                in_valid = 1'b1;
                in_data = 8'($urandom);
            end
            out_ready = ($urandom_range(99) < pr);
            if (bp && out_valid && !bp_started) begin
                bp_started = 1;
                bp_left = 5;
            end
            if (bp_left > 0) begin
                out_ready = 1'b0;
                bp_left--;
            end
            if (abort_at > 0 && src >= abort_at && out_valid) begin
                start = 1'b1;
                in_valid = 1'b1;
            end
            @(negedge clk);
            acc = in_valid & in_ready;
            chk("dp_shift_eq_accept", dp_shift, acc);
            chk("dp_x_eq_in_data", dp_x, in_data);
            if (start) begin
                chk("abort_no_shift", dp_shift, 0);
                aborted = 1;
            end else begin
                chk("busy_in_frame", busy, 1);
                chk("dp_clr_only_clear", dp_clr, 0);
                if (src < 8) chk("fill_in_ready", in_ready, 1);
                if (src >= L) chk("no_over_accept", in_ready, 0);
                if (out_valid && !out_ready) chk("bp_in_ready", in_ready, 0);
                if (ov_prev && !or_prev) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, od_prev);
                end else if (out_valid) begin
                    if (acc_cyc_q.size() > 0) chk("latency", cyc, acc_cyc_q.pop_front() + 2);
                    else chk("spurious_result", out_valid, 0);
                end
                if (out_valid && out_ready) begin
                    if (want_q.size() > 0) chk("result_data", out_data, want_q.pop_front());
                    else chk("extra_result", out_valid, 0);
                    got++;
                end
                if (done) begin
                    done_seen = 1;
                    chk("result_count", got, L - 8);
                    chk("done_all_accepted", src, L);
                    chk("done_in_ready", in_ready, 0);
                    chk("done_out_valid", out_valid, 0);
                end
            end
            ov_prev = out_valid;
            or_prev = out_ready;
            od_prev = out_data;
            @(posedge clk); #1;
            if (acc) begin
                if (src >= 8) acc_cyc_q.push_back(cyc);
                src++;
            end
            cyc++;
        end
        start = 1'b0;
        if (aborted) begin
            in_valid = 1'b0;
            @(negedge clk);
            chk("abort_clear", dp_clr, 1);
            chk("abort_out_valid", out_valid, 0);
            chk("abort_no_done", done, 0);
            @(posedge clk); #1;
        end else if (!done_seen) begin
            chk("done_timeout", done_seen, 1);
        end else begin
            in_valid = 1'b1;
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("done_pulse_width", done, 0);
            chk("idle_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        // Asynchronous reset at power-up, with live inputs.
        in_valid = 1'b1;
        #3 reset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_dp_shift", dp_shift, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_done", done, 0);
        chk("rst_dp_clr", dp_clr, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        // Releasing reset alone must not begin a frame.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_idle_busy", busy, 0);
            chk("post_rst_idle_shift", dp_shift, 0);
        end
        @(posedge clk); #1;

        run_frame(12, 100, 100, 1, 0, 0);
        run_frame(3, 100, 100, 0, 0, 0);
        run_frame(0, 100, 100, 0, 0, 0);
        run_frame(10, 100, 100, 0, 1, 0);
        run_frame(30, 20, 100, 0, 0, 0);
        run_frame(20, 100, 100, 0, 0, 10);
        run_frame(15, 100, 100, 0, 0, 0);
        for (int f = 0; f < 6; f++) begin
            run_frame($urandom_range(9, 40), $urandom_range(30, 100),
                      $urandom_range(30, 100), 0, (f % 2) == 1, 0);
        end

        // Asynchronous reset between clock edges while in FILL.
        frame_len = 16'd20;
        start = 1'b1;
        in_valid = 1'b1;
        in_data = 8'd5;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_dp_shift", dp_shift, 0);
        chk("mid_rst_dp_clr", dp_clr, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_done", done, 0);
        #2 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_rst_quiet_busy", busy, 0);
            chk("mid_rst_quiet_shift", dp_shift, 0);
        end
        @(posedge clk); #1;
        run_frame(11, 60, 70, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
